sobel_addr_seq: RTL
===================

Name: sobel_addr_seq

Overview:
- Parametrised address sequencer for the Sobel engine's word-addressed frame memory.
- For each output word it fetches three vertically adjacent source words (prev, curr, next row), waits for the filter result, then issues the write address.
- Handshakes with the memory port over req/ack and with the filter datapath over result-valid.
- Supersedes the fixed 640-wide offset counters with a frame-level FSM, configurable geometry and base addresses, and automatic end-of-frame termination.

Parameters:
- IMG_WIDTH, 640: pixels per row.
- IMG_HEIGHT, 480: rows per frame (>=3).
- PIX_PER_WORD, 4: pixels per memory word. WPR = IMG_WIDTH/PIX_PER_WORD words per row; must divide exactly.
- ADDR_W, 22: byte address width.
- BYTE_SHIFT, 2: log2 bytes per word.
- SRC_BASE, 0: source frame base, in words.
- DST_BASE, 20'h20000: destination frame base, in words.

Ports:
- clk_i  in  1  clock. Single clock domain, rising edge.
- rst_i  in  1  reset, asynchronous and active-high.
- start_i  in  1  one-cycle pulse that starts a frame. Ignored while busy_o=1.
- ack_i  in  1  memory accepted the current request.
- res_valid_i  in  1  filter result word ready for writing.
- req_o  out  1  memory request valid.
- we_o  out  1  1 = write (destination), 0 = read.
- adr_o  out  ADDR_W  byte address; low BYTE_SHIFT bits are always 0.
- row_sel_o  out  2  0 = prev, 1 = curr, 2 = next, 3 = dest.
- col_o  out  16  current output word column, 0..WPR-1.
- row_o  out  16  current output row, 0..IMG_HEIGHT-3.
- busy_o  out  1  frame in progress.
- done_o  out  1  one-cycle pulse on frame completion.

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0.
  - FSM in IDLE.
  - Word offset, col and row counters cleared.
  - Asserting rst_i mid-frame aborts immediately. No further requests until a new start_i.
- States: IDLE, RD_PREV, RD_CURR, RD_NEXT, WAIT_RES, WR.
- IDLE:
  - start_i=1 -> RD_PREV.
  - busy_o=1 and req_o=1 from the next cycle; latency start -> first request is 1 cycle.
- Word offset: off = row*WPR + col, held as one linear counter, 0..(IMG_HEIGHT-2)*WPR-1.
- Word addresses:
  - prev = SRC_BASE + off
  - curr = prev + WPR
  - next = prev + 2*WPR
  - dest = DST_BASE + off
- adr_o = word address << BYTE_SHIFT, truncated to ADDR_W (modulo 2^ADDR_W, no saturation).
- Request stability: adr_o, we_o and row_sel_o are registered and stay constant while req_o=1 and ack_i=0.
- Transfer: a transfer occurs on a rising edge with req_o=1 and ack_i=1. Transitions on transfer:
  - RD_PREV -> RD_CURR
  - RD_CURR -> RD_NEXT
  - RD_NEXT -> WAIT_RES
- WAIT_RES:
  - req_o=0.
  - res_valid_i sampled 1 -> WR (req_o=1, we_o=1, row_sel_o=3 next cycle).
  - res_valid_i already 1 during the RD_NEXT transfer cycle is still only acted on from WAIT_RES; WAIT_RES always lasts at least 1 cycle.
- WR transfer:
  - off += 1 and col += 1.
  - When col wraps from WPR-1 to 0: row += 1.
  - If not last word -> RD_PREV.
  - Last word (row = IMG_HEIGHT-3, col = WPR-1) -> IDLE, done_o=1 for 1 cycle, busy_o=0, counters cleared.
- Throughput: with ack_i and res_valid_i tied high, one output word every 5 cycles (3 reads, WAIT_RES, write). There are no back-to-back requests across WAIT_RES.
- ack_i while req_o=0 is ignored.
- start_i coinciding with the done cycle is ignored; a new start must come in IDLE.
- Output semantics in IDLE: req_o=0, we_o=0, row_sel_o=0. adr_o holds its last value except after reset (0).

Test Plan:
- Defaults, ack_i=1, res_valid_i=1, start pulse -> byte addresses:
  - prev 0x000000
  - curr 0x000280
  - next 0x000500
  - dest 0x080000, we_o=1 on the 4th request
  - second word's prev 0x000004
- IMG_WIDTH=16, IMG_HEIGHT=4:
  - WPR=4, exactly 8 output words, done_o pulses once after the dest write to byte 0x08001C.
  - Word 5 (row 1, col 0) reads 0x010, 0x020, 0x030.
- ack_i withheld 3 cycles during RD_CURR -> adr_o, we_o, row_sel_o stable for all 4 cycles; exactly one curr transfer is counted.
- res_valid_i held 0 for 10 cycles after the next-row read -> req_o=0 for 10 cycles, then a write within 1 cycle after res_valid_i rises.
- rst_i asserted mid-frame during WR with ack pending -> all outputs 0 asynchronously. A new start restarts at offset 0 (prev 0x000000).
- start_i pulsed while busy_o=1 -> no effect on the sequence or counters; the total write count is unchanged.

Source files
------------

// File: rtl/sobel_addr_seq.sv
// Frame address sequencer for the Sobel engine: three source-row reads, wait for
// the filter result, then one destination write per output word.
module sobel_addr_seq #(
  parameter int IMG_WIDTH    = 640,
  parameter int IMG_HEIGHT   = 480,
  parameter int PIX_PER_WORD = 4,
  parameter int ADDR_W       = 22,
  parameter int BYTE_SHIFT   = 2,
  parameter int SRC_BASE     = 0,
  parameter int DST_BASE     = 'h20000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              ack_i,
  input  logic              res_valid_i,
  output logic              req_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] adr_o,
  output logic [1:0]        row_sel_o,
  output logic [15:0]       col_o,
  output logic [15:0]       row_o,
  output logic              busy_o,
  output logic              done_o
);

  // state    | meaning
  // IDLE     | no frame; waits for start_i
  // RD_PREV  | read request for the row above
  // RD_CURR  | read request for the centre row
  // RD_NEXT  | read request for the row below
  // WAIT_RES | no request; waits for the filter result
  // WR       | write request to the destination frame
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] RD_PREV  = 3'd1;
  localparam logic [2:0] RD_CURR  = 3'd2;
  localparam logic [2:0] RD_NEXT  = 3'd3;
  localparam logic [2:0] WAIT_RES = 3'd4;
  localparam logic [2:0] WR       = 3'd5;

  localparam int WPR = IMG_WIDTH / PIX_PER_WORD;
  localparam logic [ADDR_W-1:0] WPR_A   = ADDR_W'(WPR);
  localparam logic [ADDR_W-1:0] SRC_A   = ADDR_W'(SRC_BASE);
  localparam logic [ADDR_W-1:0] DST_A   = ADDR_W'(DST_BASE);
  localparam logic [15:0]       COL_MAX = 16'(WPR - 1);
  localparam logic [15:0]       ROW_MAX = 16'(IMG_HEIGHT - 3);

  logic [2:0]        state_q;
  logic [ADDR_W-1:0] off_q;
  logic [ADDR_W-1:0] prev_w;
  logic [ADDR_W-1:0] prev_nx_w;
  logic              last_word;

  // Word addresses wrap modulo 2^ADDR_W before the byte shift truncates them.
  assign prev_w    = SRC_A + off_q;
  assign prev_nx_w = SRC_A + off_q + 1'b1;
  assign last_word = (row_o == ROW_MAX) && (col_o == COL_MAX);

  function automatic logic [ADDR_W-1:0] byte_adr(input logic [ADDR_W-1:0] w);
    return w << BYTE_SHIFT;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      off_q     <= '0;
      col_o     <= '0;
      row_o     <= '0;
      req_o     <= 1'b0;
      we_o      <= 1'b0;
      adr_o     <= '0;
      row_sel_o <= 2'd0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state_q)
        IDLE: begin
          // a start landing on the done pulse belongs to the finished frame
          if (start_i && !done_o) begin
            state_q   <= RD_PREV;
            req_o     <= 1'b1;
            we_o      <= 1'b0;
            row_sel_o <= 2'd0;
            adr_o     <= byte_adr(prev_w);
            busy_o    <= 1'b1;
          end
        end
        RD_PREV: if (ack_i) begin
          state_q   <= RD_CURR;
          row_sel_o <= 2'd1;
          adr_o     <= byte_adr(prev_w + WPR_A);
        end
        RD_CURR: if (ack_i) begin
          state_q   <= RD_NEXT;
          row_sel_o <= 2'd2;
          adr_o     <= byte_adr(prev_w + (WPR_A << 1));
        end
        RD_NEXT: if (ack_i) begin
          state_q <= WAIT_RES;
          req_o   <= 1'b0;
        end
        WAIT_RES: if (res_valid_i) begin
          state_q   <= WR;
          req_o     <= 1'b1;
          we_o      <= 1'b1;
          row_sel_o <= 2'd3;
          adr_o     <= byte_adr(DST_A + off_q);
        end
        WR: if (ack_i) begin
          we_o      <= 1'b0;
          row_sel_o <= 2'd0;
          if (last_word) begin
            state_q <= IDLE;
            req_o   <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
            off_q   <= '0;
            col_o   <= '0;
            row_o   <= '0;
          end else begin
            state_q <= RD_PREV;
            off_q   <= off_q + 1'b1;
            adr_o   <= byte_adr(prev_nx_w);
            if (col_o == COL_MAX) begin
              col_o <= '0;
              row_o <= row_o + 1'b1;
            end else begin
              col_o <= col_o + 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          req_o   <= 1'b0;
          we_o    <= 1'b0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule
